puf_sequencer: RTL and testbench
================================

PUF_SEQUENCER -- requirements
Module: puf_sequencer

Interface
REQ-001 Parameter CHAL_W, default 8, SHALL set the challenge width.
REQ-002 Parameter RESP_W, default 8, SHALL set the response width.
REQ-003 Parameter N_EN, default 32, SHALL set the number of arbiter-chain enable lines.
REQ-004 Parameter SETTLE, default 4, SHALL set the cycles the challenge is held with enables low before launch (minimum 1).
REQ-005 Parameter TIMEOUT, default 1024, SHALL set the maximum RACE cycles before forced capture.
REQ-006 Parameter CLEAR_CYC, default 2, SHALL set the cycles puf_ack is held high (minimum 1).
REQ-007 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  single clock; one clock, reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- start  in  1  begin a sweep; sampled in IDLE only.
- abort  in  1  terminate the sweep early.
- first_chal  in  CHAL_W  first challenge; captured on start.
- last_chal  in  CHAL_W  last challenge; captured on start.
- puf_response  in  RESP_W  response from the parallel PUF.
- puf_done  in  1  PUF completion flag.
- challenge  out  CHAL_W  challenge driven to the PUF.
- enables  out  N_EN  race launch; all bits are always equal.
- puf_ack  out  1  PUF clear (computer_ack).
- resp_data  out  RESP_W  captured response.
- resp_chal  out  CHAL_W  challenge that produced resp_data.
- resp_timeout  out  1  set when the capture was forced by timeout.
- resp_valid  out  1  response available to the host.
- resp_ack  in  1  host accepts the response.
- busy  out  1  high in every state except IDLE.
- seq_done  out  1  one-cycle end-of-sweep pulse.

Function
REQ-008 The FSM SHALL have the states IDLE, LOAD, RACE, CAPTURE, PRESENT, CLEAR and FINISH.
REQ-009 IDLE: start=1 SHALL latch first_chal/last_chal, set challenge=first_chal and enter LOAD next cycle; start SHALL be ignored in every other state.
REQ-010 LOAD: enables SHALL be 0 and challenge stable for exactly SETTLE cycles, then the FSM SHALL enter RACE.
REQ-011 RACE: enables SHALL be all ones and a cycle counter SHALL start at 1; puf_done=1 SHALL cause entry to CAPTURE with timeout=0.
REQ-012 RACE: if the counter reaches TIMEOUT without puf_done, the FSM SHALL enter CAPTURE with timeout=1; when puf_done and expiry coincide, done SHALL win (timeout=0).
REQ-013 CAPTURE (1 cycle): resp_data<=puf_response, resp_chal<=challenge and resp_timeout<=flag; enables SHALL return to 0 in this cycle.
REQ-014 PRESENT: resp_valid=1 with resp_data/resp_chal/resp_timeout held stable until resp_valid&&resp_ack at a clock edge; resp_valid SHALL drop the following cycle and the FSM SHALL enter CLEAR.
REQ-015 resp_ack outside PRESENT SHALL have no effect.
REQ-016 CLEAR: puf_ack=1 and enables=0 for exactly CLEAR_CYC cycles; afterwards, if challenge==last or an abort is pending, the FSM SHALL enter FINISH, else challenge<=challenge+1 modulo 2^CHAL_W and the FSM SHALL enter LOAD.
REQ-017 Wrap-around: when last<first the sweep SHALL run first..2^CHAL_W-1, 0..last; when first==last exactly one challenge SHALL be measured.
REQ-018 abort=1 in LOAD, RACE or CAPTURE SHALL force CLEAR next cycle with no resp_valid.
REQ-019 abort=1 in PRESENT SHALL set the abort-pending flag; the pending response SHALL still complete its handshake.
REQ-020 abort=1 in CLEAR SHALL set abort-pending; abort in IDLE or FINISH SHALL be ignored.
REQ-021 FINISH: seq_done=1 for one cycle, abort-pending SHALL clear and the FSM SHALL enter IDLE; busy SHALL be 0 from that IDLE cycle.
REQ-022 puf_ack SHALL be high only in CLEAR, and enables SHALL be high only in RACE.

Reset
REQ-023 reset=1 at a clock edge SHALL, from any state, force IDLE with challenge=0, enables=0, puf_ack=0, resp_data=0, resp_chal=0, resp_timeout=0, resp_valid=0, busy=0, seq_done=0, all counters=0 and abort-pending=0.
REQ-024 reset SHALL take priority over start, abort and resp_ack in the same cycle.
REQ-025 Reset asserted mid-RACE SHALL drop enables the next cycle, with no response presented.

Verification
REQ-026 The bench SHALL run: first=0x10, last=0x12, puf_done 5 cycles into RACE, resp_ack immediate -> three responses with resp_chal 0x10,0x11,0x12, timeout=0, then one seq_done pulse.
REQ-027 The bench SHALL run: first=0xFE, last=0x01 -> resp_chal sequence 0xFE,0xFF,0x00,0x01.
REQ-028 The bench SHALL run: puf_done never asserted, TIMEOUT=16 -> CAPTURE after 16 RACE cycles, resp_timeout=1, resp_data=current puf_response.
REQ-029 The bench SHALL run: resp_ack withheld 20 cycles -> resp_valid and data stable 20+ cycles, puf_ack not asserted until the ack is seen.
REQ-030 The bench SHALL run: abort during RACE of challenge 0x11 (first=0x10, last=0x20) -> CLEAR for CLEAR_CYC cycles, no response for 0x11, seq_done, IDLE.
REQ-031 The bench SHALL run: reset mid-PRESENT -> next cycle resp_valid=0, busy=0, all outputs at reset values; a subsequent start runs normally.

Source files
------------

// File: rtl/puf_sequencer.sv
// Challenge sweeper for a parallel arbiter PUF: walks challenges first..last
// (with wrap), launches each race, captures the response (or a timeout),
// hands it to the host through a valid/ack handshake and clears the PUF.
module puf_sequencer #(
   parameter int CHAL_W    = 8,
   parameter int RESP_W    = 8,
   parameter int N_EN      = 32,
   parameter int SETTLE    = 4,
   parameter int TIMEOUT   = 1024,
   parameter int CLEAR_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [CHAL_W-1:0] first_chal,
   input  logic [CHAL_W-1:0] last_chal,
   input  logic [RESP_W-1:0] puf_response,
   input  logic              puf_done,
   output logic [CHAL_W-1:0] challenge,
   output logic [N_EN-1:0]   enables,
   output logic              puf_ack,
   output logic [RESP_W-1:0] resp_data,
   output logic [CHAL_W-1:0] resp_chal,
   output logic              resp_timeout,
   output logic              resp_valid,
   input  logic              resp_ack,
   output logic              busy,
   output logic              seq_done
);

   // One shared counter serves LOAD settling, RACE timeout and CLEAR hold.
   localparam int CNT_MAX = (TIMEOUT > SETTLE)
                          ? ((TIMEOUT > CLEAR_CYC) ? TIMEOUT : CLEAR_CYC)
                          : ((SETTLE > CLEAR_CYC) ? SETTLE : CLEAR_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RACE    = 3'd2,
      CAPTURE = 3'd3,
      PRESENT = 3'd4,
      CLEAR   = 3'd5,
      FINISH  = 3'd6
   } state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [CHAL_W-1:0]  last_q, last_nx, chal_nx;
   logic               abort_pend, abort_nx;
   logic               tflag, tflag_nx;
   logic               cap;

   // Next-state, counter and sweep bookkeeping.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      chal_nx  = challenge;
      last_nx  = last_q;
      abort_nx = abort_pend;
      tflag_nx = tflag;
      cap      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               chal_nx  = first_chal;
               last_nx  = last_chal;
               cnt_nx   = '0;
               state_nx = LOAD;
            end else begin
               state_nx = IDLE;
            end
         end
         LOAD: begin
            if (abort) begin
               abort_nx = 1'b1;
               cnt_nx   = '0;
               state_nx = CLEAR;
            end else if (cnt == CNT_W'(SETTLE - 1)) begin
               cnt_nx   = CNT_W'(1);
               state_nx = RACE;
            end else begin
               cnt_nx   = cnt + CNT_W'(1);
            end
         end
         RACE: begin
            if (abort) begin
               abort_nx = 1'b1;
               cnt_nx   = '0;
               state_nx = CLEAR;
            end else if (puf_done) begin
               // done wins over a coinciding expiry
               tflag_nx = 1'b0;
               cnt_nx   = '0;
               state_nx = CAPTURE;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               tflag_nx = 1'b1;
               cnt_nx   = '0;
               state_nx = CAPTURE;
            end else begin
               cnt_nx   = cnt + CNT_W'(1);
            end
         end
         CAPTURE: begin
            if (abort) begin
               abort_nx = 1'b1;
               cnt_nx   = '0;
               state_nx = CLEAR;
            end else begin
               cap      = 1'b1;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            // an abort here only ends the sweep after this handshake
            abort_nx = abort_pend | abort;
            if (resp_ack) begin
               cnt_nx   = '0;
               state_nx = CLEAR;
            end else begin
               state_nx = PRESENT;
            end
         end
         CLEAR: begin
            abort_nx = abort_pend | abort;
            if (cnt == CNT_W'(CLEAR_CYC - 1)) begin
               cnt_nx = '0;
               if ((challenge == last_q) || abort_pend || abort) begin
                  state_nx = FINISH;
               end else begin
                  chal_nx  = challenge + CHAL_W'(1);
                  state_nx = LOAD;
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         FINISH: begin
            abort_nx = 1'b0;
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            abort_nx = 1'b0;
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // State register plus outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         challenge    <= '0;
         last_q       <= '0;
         abort_pend   <= 1'b0;
         tflag        <= 1'b0;
         enables      <= '0;
         puf_ack      <= 1'b0;
         resp_data    <= '0;
         resp_chal    <= '0;
         resp_timeout <= 1'b0;
         resp_valid   <= 1'b0;
         busy         <= 1'b0;
         seq_done     <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         challenge    <= chal_nx;
         last_q       <= last_nx;
         abort_pend   <= abort_nx;
         tflag        <= tflag_nx;
         enables      <= {N_EN{state_nx == RACE}};
         puf_ack      <= (state_nx == CLEAR);
         resp_valid   <= (state_nx == PRESENT);
         busy         <= (state_nx != IDLE);
         seq_done     <= (state_nx == FINISH);
         if (cap) begin
            resp_data    <= puf_response;
            resp_chal    <= challenge;
            resp_timeout <= tflag;
         end else begin
            resp_data    <= resp_data;
            resp_chal    <= resp_chal;
            resp_timeout <= resp_timeout;
         end
      end
   end

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench for puf_sequencer (SETTLE=4, TIMEOUT=16, CLEAR_CYC=2).
module tb_puf_sequencer;

   localparam logic [31:0] ALL = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset, start, abort, puf_done, resp_ack;
   logic [7:0]  first_chal, last_chal, puf_response;
   logic [7:0]  challenge, resp_data, resp_chal;
   logic [31:0] enables;
   logic        puf_ack, resp_timeout, resp_valid, busy, seq_done;

   int errors = 0;
   int checks = 0;

   puf_sequencer #(
      .CHAL_W(8), .RESP_W(8), .N_EN(32),
      .SETTLE(4), .TIMEOUT(16), .CLEAR_CYC(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_chal(first_chal), .last_chal(last_chal),
      .puf_response(puf_response), .puf_done(puf_done),
      .challenge(challenge), .enables(enables), .puf_ack(puf_ack),
      .resp_data(resp_data), .resp_chal(resp_chal),
      .resp_timeout(resp_timeout), .resp_valid(resp_valid),
      .resp_ack(resp_ack), .busy(busy), .seq_done(seq_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_sweep(input logic [7:0] f, input logic [7:0] l);
      first_chal = f;
      last_chal  = l;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_chal", {24'd0, challenge}, {24'd0, f});
   endtask

   // wait through LOAD until the race launches; returns LOAD length
   task automatic wait_race(output int lc);
      lc = 0;
      while (enables !== ALL && lc < 64) begin
         lc++;
         @(negedge clk);
      end
   endtask

   // one full measurement: LOAD, RACE, CAPTURE, PRESENT handshake, CLEAR
   task automatic measure(input logic [7:0] exp_chal, input int done_at,
                          input int ack_wait, input logic [7:0] rv, input logic exp_to);
      int lc, rc, g, pc;
      logic ok;
      puf_response = rv;
      wait_race(lc);
      check("load_len", lc, 32'd4);
      check("race_chal", {24'd0, challenge}, {24'd0, exp_chal});
      rc = 0;
      while (enables === ALL && rc < 100) begin
         rc++;
         if (rc == done_at) puf_done = 1'b1;
         @(negedge clk);
      end
      puf_done = 1'b0;
      check("race_len", rc, (done_at != 0) ? done_at : 16);
      check("cap_en_low", enables, 32'd0);
      g = 0;
      while (resp_valid !== 1'b1 && g < 8) begin
         g++;
         @(negedge clk);
      end
      check("present_lat", g, 32'd1);
      check("resp_data", {24'd0, resp_data}, {24'd0, rv});
      check("resp_chal", {24'd0, resp_chal}, {24'd0, exp_chal});
      check("resp_timeout", {31'd0, resp_timeout}, {31'd0, exp_to});
      check("present_ack_low", {31'd0, puf_ack}, 32'd0);
      ok = 1'b1;
      for (int i = 0; i < ack_wait; i++) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_data !== rv || resp_chal !== exp_chal ||
             resp_timeout !== exp_to || puf_ack !== 1'b0) ok = 1'b0;
      end
      check("hold_stable", {31'd0, ok}, 32'd1);
      resp_ack = 1'b1;
      @(negedge clk);
      resp_ack = 1'b0;
      check("valid_drop", {31'd0, resp_valid}, 32'd0);
      pc = 0;
      while (puf_ack === 1'b1 && pc < 20) begin
         if (enables !== 32'd0) ok = 1'b0;
         pc++;
         @(negedge clk);
      end
      check("clear_len", pc, 32'd2);
      check("clear_en_low", {31'd0, ok}, 32'd1);
   endtask

   task automatic expect_finish();
      check("seq_done_hi", {31'd0, seq_done}, 32'd1);
      check("finish_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("seq_done_lo", {31'd0, seq_done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic expect_reset_outputs(input string tag);
      check({tag, "_chal"}, {24'd0, challenge}, 32'd0);
      check({tag, "_en"}, enables, 32'd0);
      check({tag, "_misc"}, {26'd0, puf_ack, resp_timeout, resp_valid, busy, seq_done, 1'b0}, 32'd0);
      check({tag, "_resp"}, {16'd0, resp_data, resp_chal}, 32'd0);
   endtask

   initial begin
      int lc, pc;
      reset = 1'b1; start = 1'b1; abort = 1'b1; resp_ack = 1'b1;
      puf_done = 1'b0; first_chal = 8'h00; last_chal = 8'h00; puf_response = 8'h00;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; start = 1'b0; abort = 1'b0; resp_ack = 1'b0;
      expect_reset_outputs("rst");
      @(negedge clk);
      check("rst_idle", {31'd0, busy}, 32'd0);

      // basic sweep 0x10..0x12, done 5 cycles into RACE, immediate ack
      start_sweep(8'h10, 8'h12);
      measure(8'h10, 5, 0, 8'hA1, 1'b0);
      check("no_early_done", {31'd0, seq_done}, 32'd0);
      measure(8'h11, 5, 0, 8'hB2, 1'b0);
      measure(8'h12, 5, 0, 8'hC3, 1'b0);
      expect_finish();

      // wrap-around sweep 0xFE..0x01
      start_sweep(8'hFE, 8'h01);
      measure(8'hFE, 3, 0, 8'h11, 1'b0);
      measure(8'hFF, 3, 0, 8'h22, 1'b0);
      measure(8'h00, 3, 0, 8'h33, 1'b0);
      measure(8'h01, 3, 0, 8'h44, 1'b0);
      expect_finish();

      // timeout with a single challenge (first == last)
      start_sweep(8'h33, 8'h33);
      measure(8'h33, 0, 0, 8'h5C, 1'b1);
      expect_finish();

      // host withholds ack for 20 cycles
      start_sweep(8'h40, 8'h40);
      measure(8'h40, 2, 20, 8'h9E, 1'b0);
      expect_finish();

      // abort during RACE of 0x11
      start_sweep(8'h10, 8'h20);
      measure(8'h10, 4, 0, 8'h77, 1'b0);
      wait_race(lc);
      check("abort_chal", {24'd0, challenge}, 32'h11);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_clear", {30'd0, puf_ack, resp_valid}, 32'd2);
      check("abort_en", enables, 32'd0);
      pc = 0;
      while (puf_ack === 1'b1 && pc < 20) begin
         if (resp_valid !== 1'b0) pc = 100;
         pc++;
         @(negedge clk);
      end
      check("abort_clear_len", pc, 32'd2);
      check("abort_resp_chal", {24'd0, resp_chal}, 32'h10);
      expect_finish();

      // reset mid-PRESENT, with start/abort/ack also high
      start_sweep(8'h50, 8'h52);
      wait_race(lc);
      puf_done = 1'b1;
      @(negedge clk);
      puf_done = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", {31'd0, resp_valid}, 32'd1);
      reset = 1'b1; start = 1'b1; abort = 1'b1; resp_ack = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; abort = 1'b0; resp_ack = 1'b0;
      expect_reset_outputs("rstp");
      @(negedge clk);
      check("rstp_idle", {31'd0, busy}, 32'd0);
      start_sweep(8'h60, 8'h60);
      measure(8'h60, 6, 1, 8'hE5, 1'b0);
      expect_finish();

      // reset mid-RACE drops enables next cycle, nothing presented
      start_sweep(8'h70, 8'h71);
      wait_race(lc);
      check("rr_en_hi", enables, ALL);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rr_en_lo", enables, 32'd0);
      repeat (3) @(negedge clk);
      check("rr_quiet", {30'd0, resp_valid, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
